// File: rtl/run_det_pkg.sv
// Shared types and defaults for the run-length detector.
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10
  } run_state_e;

  localparam int DEF_RUN_LEN = 2;
  localparam int DEF_CNT_W   = 4;

endpackage

// File: rtl/run_det_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable.
// Exposes its next value so the FSM can decide on the same edge.
module run_det_sat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt
);

  localparam logic [CNT_W-1:0] LP_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;

endmodule

// File: rtl/run_detector.sv
// Moore run-length detector; z high while RUN_LEN+ matches in a row.
// Define RUN_DET_PULSE_EN to build the z_pulse entry strobe.
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             w,
  input  logic             pol,
  input  logic             en,
  input  logic             clr,
  output logic             z,
  output logic             z_pulse,
  output logic [CNT_W-1:0] run_cnt
);

  if ((RUN_LEN < 1) || (RUN_LEN > (2**CNT_W) - 1)) begin : g_bad_run_len
    $error("run_detector: RUN_LEN out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LP_RUN = CNT_W'(RUN_LEN);

  run_state_e       r_state;
  run_state_e       w_state_nxt;
  logic             w_match;
  logic             w_illegal;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_match   = (w == pol);
  assign w_illegal = (r_state != IDLE) && (r_state != RUN) &&
                     (r_state != HIT);
  // Illegal state also clears the count so state and count stay consistent.
  assign w_cnt_clr = clr | w_illegal | (en & ~w_match);
  assign w_cnt_inc = en & w_match;

  run_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (Clock),
    .rst_n    (Resetn),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .o_cnt    (w_cnt),
    .o_cnt_nxt(w_cnt_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (clr || w_illegal) begin
      w_state_nxt = IDLE;
    end else if (en) begin
      if (!w_match) begin
        w_state_nxt = IDLE;
      end else if (w_cnt_nxt >= LP_RUN) begin
        w_state_nxt = HIT;
      end else begin
        w_state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign z       = (r_state == HIT);
  assign run_cnt = w_cnt;

`ifdef RUN_DET_PULSE_EN
  logic r_pulse;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= (w_state_nxt == HIT) && (r_state != HIT);
    end
  end

  assign z_pulse = r_pulse;
`else
  assign z_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_run_detector.sv
// Directed, table-driven bench for run_detector (RUN_LEN=3 and RUN_LEN=1).
module tb_run_detector;

`ifdef RUN_DET_PULSE_EN
  localparam bit PULSE_ON = 1'b1;
`else
  localparam bit PULSE_ON = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       w;
  logic       pol;
  logic       en;
  logic       clr;
  logic       z3;
  logic       p3;
  logic [3:0] c3;
  logic       z1;
  logic       p1;
  logic [3:0] c1;

  int total;
  int bad;

  typedef struct {
    logic w;
    logic pol;
    logic en;
    logic clr;
    logic ez;
    logic ep;
    int   ec;
  } vec_t;

  vec_t vq[$];

  run_detector #(.RUN_LEN(3), .CNT_W(4)) u_dut3 (
    .Clock  (clk),
    .Resetn (rstn),
    .w      (w),
    .pol    (pol),
    .en     (en),
    .clr    (clr),
    .z      (z3),
    .z_pulse(p3),
    .run_cnt(c3)
  );

  run_detector #(.RUN_LEN(1), .CNT_W(4)) u_dut1 (
    .Clock  (clk),
    .Resetn (rstn),
    .w      (w),
    .pol    (pol),
    .en     (en),
    .clr    (clr),
    .z      (z1),
    .z_pulse(p1),
    .run_cnt(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic void add(input logic vw, input logic vpol,
                              input logic ven, input logic vclr,
                              input logic ez, input logic ep, input int ec);
    vec_t v;
    v.w   = vw;
    v.pol = vpol;
    v.en  = ven;
    v.clr = vclr;
    v.ez  = ez;
    v.ep  = ep;
    v.ec  = ec;
    vq.push_back(v);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".z"}, int'(z3), 0);
    check({tag, ".p"}, int'(p3), 0);
    check({tag, ".cnt"}, int'(c3), 0);
    check({tag, ".z1"}, int'(z1), 0);
    check({tag, ".cnt1"}, int'(c1), 0);
  endtask

  initial begin
    int prev_cnt;
    int ep1;
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    w     = 1'b0;
    pol   = 1'b1;
    en    = 1'b1;
    clr   = 1'b0;

    // Released with w=0: stays idle.
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 0);
    // Basic run of five.
    for (int i = 1; i <= 5; i++) add(1, 1, 1, 0, i >= 3, i == 3, i);
    // Broken run.
    add(0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 2);
    add(0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 2);
    add(1, 1, 1, 0, 1, 1, 3);
    // Saturation over 20 matches.
    add(0, 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++)
      add(1, 1, 1, 0, i >= 3, i == 3, (i > 15) ? 15 : i);
    // Enable low holds everything, even with a non-match on w.
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1, 0, 15);
    add(0, 1, 0, 0, 1, 0, 15);
    // Clear wins over en=0.
    add(1, 1, 0, 1, 0, 0, 0);
    // Polarity 0 run.
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 2);
    add(0, 0, 1, 0, 1, 1, 3);
    // Polarity flip mid-run keeps the run going.
    add(1, 1, 1, 0, 1, 0, 4);
    add(0, 1, 1, 0, 0, 0, 0);
    // Clear wins over an enabled match.
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 2);
    add(1, 1, 1, 0, 1, 1, 3);
    add(1, 1, 1, 1, 0, 0, 0);
    // New run after clear gives a fresh pulse.
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 2);
    add(1, 1, 1, 0, 1, 1, 3);
    add(1, 1, 1, 0, 1, 0, 4);

    #1;
    check_all_zero("rst_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end
    @(negedge clk);
    rstn = 1'b1;

    prev_cnt = 0;
    foreach (vq[i]) begin
      @(negedge clk);
      w   = vq[i].w;
      pol = vq[i].pol;
      en  = vq[i].en;
      clr = vq[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.z", i), int'(z3), int'(vq[i].ez));
      check($sformatf("v%0d.p", i), int'(p3),
            PULSE_ON ? int'(vq[i].ep) : 0);
      check($sformatf("v%0d.cnt", i), int'(c3), vq[i].ec);
      check($sformatf("v%0d.z1", i), int'(z1), int'(vq[i].ec != 0));
      ep1 = (prev_cnt == 0 && vq[i].ec != 0) ? 1 : 0;
      check($sformatf("v%0d.p1", i), int'(p1), PULSE_ON ? ep1 : 0);
      check($sformatf("v%0d.cnt1", i), int'(c1), vq[i].ec);
      prev_cnt = vq[i].ec;
    end

    // Asynchronous reset between edges while in HIT.
    @(negedge clk);
    w   = 1'b1;
    pol = 1'b1;
    en  = 1'b1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("pre_arst.z", int'(z3), 1);
    check("pre_arst.cnt", int'(c3), 5);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rstn = 1'b1;
    w    = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("post_arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
